ex_fwd_ctrl: RTL and testbench
==============================

# ex_fwd_ctrl

Parametrised EX-stage operand-forwarding and hazard controller for the five-stage pipeline, sitting between the ID/EX register and the EX operand muxes. For each of `RD_PORTS` source operands it selects the ID/EX, EX/MEM or MEM/WB value. It raises a stall on load-use hazards and on operands owned by in-flight multi-cycle operations. Those operations are tracked in a per-register pending scoreboard.

## Interface
Parameters:
- `RD_PORTS`, 2: number of EX source operands.
- `REG_IDX_W`, 5: register index width; scoreboard has 2^`REG_IDX_W` entries.

Ports:
- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `id2ex_rs_en_i` in `RD_PORTS`: operand p reads a register.
- `id2ex_rs_idx_i` in `RD_PORTS*REG_IDX_W`: operand p index, port p at bits [p*`REG_IDX_W` +: `REG_IDX_W`].
- `id2ex_fwd_allow_i` in `RD_PORTS`: operand p may take forwarded data; when low, only ID/EX is selected.
- `ex2mem_rd_en_i` in 1: EX/MEM writes rd.
- `ex2mem_rd_idx_i` in `REG_IDX_W`: EX/MEM rd.
- `ex2mem_is_load_i` in 1: EX/MEM holds a load.
- `mem2wb_rd_en_i` in 1: MEM/WB writes rd.
- `mem2wb_rd_idx_i` in `REG_IDX_W`: MEM/WB rd.
- `mc_issue_i` in 1: multi-cycle op leaves EX this cycle.
- `mc_issue_idx_i` in `REG_IDX_W`: its rd.
- `mc_done_i` in 1: multi-cycle result occupies MEM/WB this cycle.
- `mc_done_idx_i` in `REG_IDX_W`: its rd.
- `fwd_sel_o` out `2*RD_PORTS`: per port 2'b00 ID/EX, 2'b01 EX/MEM, 2'b10 MEM/WB; 2'b11 never driven.
- `stall_o` out 1: hold PC, IF/ID and ID/EX; bubble into EX/MEM.
- `sb_busy_o` out 1: any scoreboard bit set.

## Operation
- Match for port p against stage s: `id2ex_rs_en_i[p]` high, `id2ex_fwd_allow_i[p]` high, s rd_en high, s rd index nonzero, s rd index equals rs index.
- `fwd_sel_o`: EX/MEM match beats MEM/WB match; with neither, 2'b00.
- Load-use: EX/MEM match on any port while `ex2mem_is_load_i` is high causes `stall_o` = 1. `fwd_sel_o` is still driven to 2'b01, but the value is ignored while stalled.
- Scoreboard: a `2^REG_IDX_W`-bit register `sb_q`.
  - Set bit `mc_issue_idx_i` on `mc_issue_i`.
  - Clear bit `mc_done_idx_i` on `mc_done_i`.
  - Index 0 is never set.
  - Set and clear of the same index in the same cycle: set wins.
  - Issue to an already-pending index: bit stays set, with no error.
- Scoreboard stall: port p enabled and `sb_q[rs_idx]` set raises `stall_o`. Exception: `mc_done_i` is high with `mc_done_idx_i` equal to that index in the same cycle. That is a bypass: the operand is forwarded from MEM/WB, so there is no stall.
- Scoreboard hazards stall regardless of `id2ex_fwd_allow_i`.
- `stall_o` = load-use OR scoreboard stall, OR-reduced across ports. It is purely combinational from inputs and `sb_q`.

## Timing
- `fwd_sel_o` and `stall_o` are combinational, with zero-cycle latency.
- Scoreboard updates become visible the cycle after `mc_issue_i`/`mc_done_i`.
- A dependent instruction in ID during the issue cycle reaches EX next cycle and sees the bit set.
- `sb_busy_o` is registered, equal to OR(`sb_q`).
- Reset: `sb_q` = 0, `sb_busy_o` = 0. With inputs idle, `fwd_sel_o` = 0 and `stall_o` = 0.
- Reset mid-operation drops all pending entries. The pipeline flush owns the consistency of in-flight ops.
- While `stall_o` is high the upstream stages keep their inputs stable. The scoreboard still updates every cycle.

## Configuration
- `EX_FWD_PERF_EN` defined:
  - adds outputs `perf_lu_stall_o` [31:0] and `perf_sb_stall_o` [31:0].
  - Each counts cycles where the respective stall cause is active. Both causes in the same cycle increment both counters.
  - Counters saturate at 32'hFFFF_FFFF and reset to 0.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

## Structure
- Shared package `defines.v` holds:
  - `FWD_SEL_ID2EX` = 2'b00, `FWD_SEL_EX2MEM` = 2'b01, `FWD_SEL_MEM2WB` = 2'b10.
  - the existing `REG_INDEX_BUS`/`REG_INDEX_SIZE`.
- One sub-module, `ex_fwd_port`, instantiated `RD_PORTS` times via generate. It computes per-port match, select, load-use hit and scoreboard hit, taking `sb_q` and the stage fields as inputs.
- The top level holds `sb_q`, the stall OR-reduction and the perf counters.

## Test plan
- rs1 = x5, ex2mem rd = x5, mem2wb rd = x5, both en -> `fwd_sel_o[1:0]` = 2'b01, no stall.
- rs2 = x0, ex2mem rd = x0 en -> `fwd_sel_o[3:2]` = 2'b00; rs1 = x7 with `fwd_allow` = 0 and mem2wb rd = x7 -> 2'b00.
- ex2mem load rd = x3, rs2 = x3 -> `stall_o` = 1 for that cycle only. The next cycle, with the load in MEM/WB -> 2'b10, `stall_o` = 0.
- `mc_issue_i` x9, then rs1 = x9 for 10 cycles -> `stall_o` = 1 throughout. Cycle with `mc_done_i` x9 and mem2wb rd = x9 -> `stall_o` = 0, sel 2'b10. Next cycle `sb_busy_o` = 0.
- Same-cycle `mc_issue_i` x4 and `mc_done_i` x4 -> bit 4 remains set. `rst` pulse -> `sb_q` = 0, `sb_busy_o` = 0 the cycle after.
- `EX_FWD_PERF_EN`: 5 load-use stalls plus 3 scoreboard stalls -> `perf_lu_stall_o` = 5, `perf_sb_stall_o` = 3.

Source files
------------

// File: rtl/ex_fwd_ctrl_pkg.sv
// Shared definitions for the EX-stage forwarding/hazard controller:
// operand-select encodings and the register index width.
package ex_fwd_ctrl_pkg;

   localparam int REG_INDEX_SIZE = 5;

   typedef logic [REG_INDEX_SIZE-1:0] reg_index_bus_t;

   typedef enum logic [1:0] {
      FWD_SEL_ID2EX  = 2'b00,
      FWD_SEL_EX2MEM = 2'b01,
      FWD_SEL_MEM2WB = 2'b10
   } fwd_sel_e;

endpackage

// File: rtl/ex_fwd_ctrl_port.sv
// Per-operand forwarding decision: stage matches, operand select,
// load-use hit and pending-scoreboard hit for one EX source operand.
module ex_fwd_port
   import ex_fwd_ctrl_pkg::*;
#(
   parameter int REG_IDX_W = REG_INDEX_SIZE
) (
   input  logic                        rs_en,
   input  logic [REG_IDX_W-1:0]        rs_idx,
   input  logic                        fwd_allow,
   input  logic                        ex_rd_en,
   input  logic [REG_IDX_W-1:0]        ex_rd_idx,
   input  logic                        ex_is_load,
   input  logic                        wb_rd_en,
   input  logic [REG_IDX_W-1:0]        wb_rd_idx,
   input  logic [(1<<REG_IDX_W)-1:0]   sb_q,
   input  logic                        mc_done,
   input  logic [REG_IDX_W-1:0]        mc_done_idx,
   output logic [1:0]                  fwd_sel,
   output logic                        lu_hit,
   output logic                        sb_hit
);

   logic ex_match;
   logic wb_match;

   // Youngest producer wins; a result retiring from MEM/WB this cycle bypasses a pending bit
   always_comb begin
      ex_match = 1'b0;
      wb_match = 1'b0;
      fwd_sel  = FWD_SEL_ID2EX;
      lu_hit   = 1'b0;
      sb_hit   = 1'b0;

      ex_match = rs_en && fwd_allow && ex_rd_en && (ex_rd_idx != '0) && (ex_rd_idx == rs_idx);
      wb_match = rs_en && fwd_allow && wb_rd_en && (wb_rd_idx != '0) && (wb_rd_idx == rs_idx);

      if (ex_match) begin
         fwd_sel = FWD_SEL_EX2MEM;
      end else if (wb_match) begin
         fwd_sel = FWD_SEL_MEM2WB;
      end

      lu_hit = ex_match && ex_is_load;
      sb_hit = rs_en && sb_q[rs_idx] && !(mc_done && (mc_done_idx == rs_idx));
   end

endmodule

// File: rtl/ex_fwd_ctrl.sv
// EX-stage operand forwarding and hazard controller. Holds the pending
// scoreboard for multi-cycle ops and ORs per-port hazards into one stall.
// Optional feature macro: EX_FWD_PERF_EN adds saturating stall-cause counters.
module ex_fwd_ctrl
   import ex_fwd_ctrl_pkg::*;
#(
   parameter int RD_PORTS  = 2,
   parameter int REG_IDX_W = REG_INDEX_SIZE
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [RD_PORTS-1:0]           id2ex_rs_en_i,
   input  logic [RD_PORTS*REG_IDX_W-1:0] id2ex_rs_idx_i,
   input  logic [RD_PORTS-1:0]           id2ex_fwd_allow_i,
   input  logic                          ex2mem_rd_en_i,
   input  logic [REG_IDX_W-1:0]          ex2mem_rd_idx_i,
   input  logic                          ex2mem_is_load_i,
   input  logic                          mem2wb_rd_en_i,
   input  logic [REG_IDX_W-1:0]          mem2wb_rd_idx_i,
   input  logic                          mc_issue_i,
   input  logic [REG_IDX_W-1:0]          mc_issue_idx_i,
   input  logic                          mc_done_i,
   input  logic [REG_IDX_W-1:0]          mc_done_idx_i,
   output logic [2*RD_PORTS-1:0]         fwd_sel_o,
   output logic                          stall_o,
   output logic                          sb_busy_o
`ifdef EX_FWD_PERF_EN
   ,
   output logic [31:0]                   perf_lu_stall_o,
   output logic [31:0]                   perf_sb_stall_o
`endif
);

   localparam int SB_DEPTH = 1 << REG_IDX_W;

   logic [SB_DEPTH-1:0] sb_q;
   logic [SB_DEPTH-1:0] sb_d;
   logic                sb_busy_q;
   logic [RD_PORTS-1:0] lu_hit;
   logic [RD_PORTS-1:0] sb_hit;
   logic                lu_stall;
   logic                sb_stall;

   for (genvar p = 0; p < RD_PORTS; p++) begin : g_port
      ex_fwd_port #(
         .REG_IDX_W (REG_IDX_W)
      ) u_port (
         .rs_en       (id2ex_rs_en_i[p]),
         .rs_idx      (id2ex_rs_idx_i[p*REG_IDX_W +: REG_IDX_W]),
         .fwd_allow   (id2ex_fwd_allow_i[p]),
         .ex_rd_en    (ex2mem_rd_en_i),
         .ex_rd_idx   (ex2mem_rd_idx_i),
         .ex_is_load  (ex2mem_is_load_i),
         .wb_rd_en    (mem2wb_rd_en_i),
         .wb_rd_idx   (mem2wb_rd_idx_i),
         .sb_q        (sb_q),
         .mc_done     (mc_done_i),
         .mc_done_idx (mc_done_idx_i),
         .fwd_sel     (fwd_sel_o[2*p +: 2]),
         .lu_hit      (lu_hit[p]),
         .sb_hit      (sb_hit[p])
      );
   end

   assign lu_stall  = |lu_hit;
   assign sb_stall  = |sb_hit;
   assign stall_o   = lu_stall || sb_stall;
   assign sb_busy_o = sb_busy_q;

   // Next scoreboard: clear on completion first so a same-cycle re-issue wins; x0 never pends
   always_comb begin
      sb_d = sb_q;
      if (mc_done_i) begin
         sb_d[mc_done_idx_i] = 1'b0;
      end
      if (mc_issue_i && (mc_issue_idx_i != '0)) begin
         sb_d[mc_issue_idx_i] = 1'b1;
      end
   end

   // Scoreboard register; busy flag tracks the new contents so it always equals OR of sb_q
   always_ff @(posedge clk) begin
      if (rst) begin
         sb_q      <= '0;
         sb_busy_q <= 1'b0;
      end else begin
         sb_q      <= sb_d;
         sb_busy_q <= |sb_d;
      end
   end

`ifdef EX_FWD_PERF_EN
   // Saturating per-cause stall cycle counters
   always_ff @(posedge clk) begin
      if (rst) begin
         perf_lu_stall_o <= '0;
         perf_sb_stall_o <= '0;
      end else begin
         if (lu_stall && (perf_lu_stall_o != 32'hFFFF_FFFF)) begin
            perf_lu_stall_o <= perf_lu_stall_o + 32'd1;
         end
         if (sb_stall && (perf_sb_stall_o != 32'hFFFF_FFFF)) begin
            perf_sb_stall_o <= perf_sb_stall_o + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_ex_fwd_ctrl.sv
// Self-checking bench for ex_fwd_ctrl: directed vector table, hand-written
// multi-cycle sequences and randomized traffic against a reference model.
module tb_ex_fwd_ctrl;

   localparam int RD_PORTS  = 2;
   localparam int REG_IDX_W = 5;
   localparam longint CNT_MAX = 64'h0000_0000_FFFF_FFFF;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [1:0]  id2ex_rs_en_i;
   logic [9:0]  id2ex_rs_idx_i;
   logic [1:0]  id2ex_fwd_allow_i;
   logic        ex2mem_rd_en_i;
   logic [4:0]  ex2mem_rd_idx_i;
   logic        ex2mem_is_load_i;
   logic        mem2wb_rd_en_i;
   logic [4:0]  mem2wb_rd_idx_i;
   logic        mc_issue_i;
   logic [4:0]  mc_issue_idx_i;
   logic        mc_done_i;
   logic [4:0]  mc_done_idx_i;
   logic [3:0]  fwd_sel_o;
   logic        stall_o;
   logic        sb_busy_o;
`ifdef EX_FWD_PERF_EN
   logic [31:0] perf_lu_stall_o;
   logic [31:0] perf_sb_stall_o;
`endif

   always #5 clk = ~clk;

   ex_fwd_ctrl #(
      .RD_PORTS  (RD_PORTS),
      .REG_IDX_W (REG_IDX_W)
   ) dut (
      .clk               (clk),
      .rst               (rst),
      .id2ex_rs_en_i     (id2ex_rs_en_i),
      .id2ex_rs_idx_i    (id2ex_rs_idx_i),
      .id2ex_fwd_allow_i (id2ex_fwd_allow_i),
      .ex2mem_rd_en_i    (ex2mem_rd_en_i),
      .ex2mem_rd_idx_i   (ex2mem_rd_idx_i),
      .ex2mem_is_load_i  (ex2mem_is_load_i),
      .mem2wb_rd_en_i    (mem2wb_rd_en_i),
      .mem2wb_rd_idx_i   (mem2wb_rd_idx_i),
      .mc_issue_i        (mc_issue_i),
      .mc_issue_idx_i    (mc_issue_idx_i),
      .mc_done_i         (mc_done_i),
      .mc_done_idx_i     (mc_done_idx_i),
      .fwd_sel_o         (fwd_sel_o),
      .stall_o           (stall_o),
      .sb_busy_o         (sb_busy_o)
`ifdef EX_FWD_PERF_EN
      ,
      .perf_lu_stall_o   (perf_lu_stall_o),
      .perf_sb_stall_o   (perf_sb_stall_o)
`endif
   );

   typedef struct {
      logic [1:0] rs_en;
      logic [1:0] allow;
      logic [4:0] idx0;
      logic [4:0] idx1;
      logic       ex_en;
      logic [4:0] ex_idx;
      logic       ex_load;
      logic       wb_en;
      logic [4:0] wb_idx;
      logic       iss;
      logic [4:0] iss_idx;
      logic       done;
      logic [4:0] done_idx;
   } in_t;

   typedef struct {
      in_t        in;
      logic [3:0] sel;
      logic       stall;
   } vec_t;

   bit     pend [32];
   longint luCnt;
   longint sbCnt;
   int     checks = 0;
   int     errors = 0;

   function automatic in_t idleIn();
      in_t v;
      v.rs_en = 2'b00; v.allow = 2'b00; v.idx0 = 5'd0; v.idx1 = 5'd0;
      v.ex_en = 1'b0; v.ex_idx = 5'd0; v.ex_load = 1'b0;
      v.wb_en = 1'b0; v.wb_idx = 5'd0;
      v.iss = 1'b0; v.iss_idx = 5'd0; v.done = 1'b0; v.done_idx = 5'd0;
      return v;
   endfunction

   function automatic in_t mkIn(input logic [1:0] rsEn, input logic [1:0] allow,
                                input logic [4:0] i0, input logic [4:0] i1,
                                input logic exEn, input logic [4:0] exIdx, input logic exLoad,
                                input logic wbEn, input logic [4:0] wbIdx);
      in_t v;
      v = idleIn();
      v.rs_en = rsEn; v.allow = allow; v.idx0 = i0; v.idx1 = i1;
      v.ex_en = exEn; v.ex_idx = exIdx; v.ex_load = exLoad;
      v.wb_en = wbEn; v.wb_idx = wbIdx;
      return v;
   endfunction

   function automatic vec_t mkVec(input in_t v, input logic [3:0] sel, input logic stall);
      vec_t t;
      t.in = v; t.sel = sel; t.stall = stall;
      return t;
   endfunction

   task automatic applyStimulus(input in_t v);
      id2ex_rs_en_i     = v.rs_en;
      id2ex_rs_idx_i    = {v.idx1, v.idx0};
      id2ex_fwd_allow_i = v.allow;
      ex2mem_rd_en_i    = v.ex_en;
      ex2mem_rd_idx_i   = v.ex_idx;
      ex2mem_is_load_i  = v.ex_load;
      mem2wb_rd_en_i    = v.wb_en;
      mem2wb_rd_idx_i   = v.wb_idx;
      mc_issue_i        = v.iss;
      mc_issue_idx_i    = v.iss_idx;
      mc_done_i         = v.done;
      mc_done_idx_i     = v.done_idx;
   endtask

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: select/stall derived from the operand rules and the pending-register list
   task automatic modelComb(input in_t v, output logic [3:0] sel, output logic lu, output logic sb);
      logic [4:0] rs [2];
      bit usable, fromEx, fromWb;
      rs[0] = v.idx0;
      rs[1] = v.idx1;
      sel = 4'd0; lu = 1'b0; sb = 1'b0;
      for (int p = 0; p < 2; p++) begin
         usable = v.rs_en[p] && v.allow[p];
         fromEx = usable && v.ex_en && (v.ex_idx != 0) && (v.ex_idx == rs[p]);
         fromWb = usable && v.wb_en && (v.wb_idx != 0) && (v.wb_idx == rs[p]);
         sel[2*p +: 2] = fromEx ? 2'd1 : (fromWb ? 2'd2 : 2'd0);
         if (fromEx && v.ex_load) lu = 1'b1;
         if (v.rs_en[p] && pend[rs[p]] && !(v.done && (v.done_idx == rs[p]))) sb = 1'b1;
      end
   endtask

   task automatic runCycle(input in_t v, input bit useConst, input logic [3:0] eSel,
                           input logic eStall, input logic eBusy);
      logic [3:0] mSel;
      logic mLu, mSb, busy;
      @(negedge clk);
      applyStimulus(v);
      #1;
      modelComb(v, mSel, mLu, mSb);
      checkOutput("fwd_sel", {28'd0, fwd_sel_o}, {28'd0, mSel});
      checkOutput("stall", {31'd0, stall_o}, {31'd0, mLu | mSb});
      if (useConst) begin
         checkOutput("fwd_sel_vec", {28'd0, fwd_sel_o}, {28'd0, eSel});
         checkOutput("stall_vec", {31'd0, stall_o}, {31'd0, eStall});
      end
      @(posedge clk);
      if (v.done) pend[v.done_idx] = 1'b0;
      if (v.iss && (v.iss_idx != 0)) pend[v.iss_idx] = 1'b1;
      if (mLu && luCnt < CNT_MAX) luCnt++;
      if (mSb && sbCnt < CNT_MAX) sbCnt++;
      #1;
      busy = 1'b0;
      foreach (pend[i]) if (pend[i]) busy = 1'b1;
      checkOutput("sb_busy", {31'd0, sb_busy_o}, {31'd0, busy});
      if (useConst) checkOutput("sb_busy_vec", {31'd0, sb_busy_o}, {31'd0, eBusy});
`ifdef EX_FWD_PERF_EN
      checkOutput("perf_lu", perf_lu_stall_o, luCnt[31:0]);
      checkOutput("perf_sb", perf_sb_stall_o, sbCnt[31:0]);
`endif
   endtask

   task automatic doReset();
      @(negedge clk);
      applyStimulus(idleIn());
      rst = 1'b1;
      @(posedge clk);
      foreach (pend[i]) pend[i] = 1'b0;
      luCnt = 0;
      sbCnt = 0;
      #1;
      checkOutput("rst_sb_busy", {31'd0, sb_busy_o}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      checkOutput("rst_fwd_sel", {28'd0, fwd_sel_o}, 32'd0);
      checkOutput("rst_stall", {31'd0, stall_o}, 32'd0);
   endtask

   vec_t tbl [9];
   in_t  v;

   initial begin
      applyStimulus(idleIn());
      foreach (pend[i]) pend[i] = 1'b0;
      luCnt = 0;
      sbCnt = 0;

      tbl[0] = mkVec(mkIn(2'b01, 2'b01, 5'd5, 5'd0, 1'b1, 5'd5, 1'b0, 1'b1, 5'd5), 4'b0001, 1'b0);
      tbl[1] = mkVec(mkIn(2'b11, 2'b10, 5'd7, 5'd0, 1'b1, 5'd0, 1'b0, 1'b1, 5'd7), 4'b0000, 1'b0);
      tbl[2] = mkVec(mkIn(2'b10, 2'b10, 5'd0, 5'd3, 1'b1, 5'd3, 1'b1, 1'b0, 5'd0), 4'b0100, 1'b1);
      tbl[3] = mkVec(mkIn(2'b10, 2'b10, 5'd0, 5'd3, 1'b0, 5'd0, 1'b0, 1'b1, 5'd3), 4'b1000, 1'b0);
      tbl[4] = mkVec(mkIn(2'b11, 2'b11, 5'd6, 5'd6, 1'b1, 5'd6, 1'b0, 1'b1, 5'd6), 4'b0101, 1'b0);
      tbl[5] = mkVec(mkIn(2'b11, 2'b11, 5'd8, 5'd9, 1'b1, 5'd9, 1'b1, 1'b1, 5'd8), 4'b0110, 1'b1);
      tbl[6] = mkVec(mkIn(2'b01, 2'b00, 5'd3, 5'd0, 1'b1, 5'd3, 1'b1, 1'b0, 5'd0), 4'b0000, 1'b0);
      tbl[7] = mkVec(mkIn(2'b00, 2'b11, 5'd4, 5'd4, 1'b1, 5'd4, 1'b0, 1'b1, 5'd4), 4'b0000, 1'b0);
      tbl[8] = mkVec(mkIn(2'b01, 2'b01, 5'd4, 5'd0, 1'b0, 5'd4, 1'b0, 1'b1, 5'd4), 4'b0010, 1'b0);

      doReset();

      for (int i = 0; i < 9; i++) begin
         runCycle(tbl[i].in, 1'b1, tbl[i].sel, tbl[i].stall, 1'b0);
      end

      // Multi-cycle op on x9: dependent waits until the result sits in MEM/WB
      v = mkIn(2'b01, 2'b01, 5'd9, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0);
      v.iss = 1'b1; v.iss_idx = 5'd9;
      runCycle(v, 1'b1, 4'b0000, 1'b0, 1'b1);
      for (int i = 0; i < 10; i++) begin
         v = mkIn(2'b01, {1'b0, i[0]}, 5'd9, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0);
         runCycle(v, 1'b1, 4'b0000, 1'b1, 1'b1);
      end
      v = mkIn(2'b01, 2'b01, 5'd9, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd9);
      v.done = 1'b1; v.done_idx = 5'd9;
      runCycle(v, 1'b1, 4'b0010, 1'b0, 1'b0);

      // Issue to x0 never pends
      v = idleIn();
      v.iss = 1'b1; v.iss_idx = 5'd0;
      runCycle(v, 1'b1, 4'b0000, 1'b0, 1'b0);

      // Same-cycle issue and completion on x4: issue wins
      v = idleIn();
      v.iss = 1'b1; v.iss_idx = 5'd4; v.done = 1'b1; v.done_idx = 5'd4;
      runCycle(v, 1'b1, 4'b0000, 1'b0, 1'b1);
      v = mkIn(2'b10, 2'b10, 5'd0, 5'd4, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0);
      runCycle(v, 1'b1, 4'b0000, 1'b1, 1'b1);

      // Reset drops the pending entry
      doReset();
      v = mkIn(2'b10, 2'b10, 5'd0, 5'd4, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0);
      runCycle(v, 1'b1, 4'b0000, 1'b0, 1'b0);

      // Five load-use stalls then three scoreboard stalls
      for (int i = 0; i < 5; i++) begin
         v = mkIn(2'b10, 2'b10, 5'd0, 5'd3, 1'b1, 5'd3, 1'b1, 1'b0, 5'd0);
         runCycle(v, 1'b1, 4'b0100, 1'b1, 1'b0);
      end
      v = idleIn();
      v.iss = 1'b1; v.iss_idx = 5'd12;
      runCycle(v, 1'b1, 4'b0000, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) begin
         v = mkIn(2'b01, 2'b01, 5'd12, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0);
         runCycle(v, 1'b1, 4'b0000, 1'b1, 1'b1);
      end
      v = idleIn();
      v.done = 1'b1; v.done_idx = 5'd12;
      runCycle(v, 1'b1, 4'b0000, 1'b0, 1'b0);
`ifdef EX_FWD_PERF_EN
      checkOutput("perf_lu_total", perf_lu_stall_o, 32'd5);
      checkOutput("perf_sb_total", perf_sb_stall_o, 32'd3);
`endif

      // Randomized traffic over a small register window to provoke collisions
      for (int i = 0; i < 400; i++) begin
         v.rs_en    = 2'($urandom_range(0, 3));
         v.allow    = 2'($urandom_range(0, 3));
         v.idx0     = 5'($urandom_range(0, 7));
         v.idx1     = 5'($urandom_range(0, 7));
         v.ex_en    = 1'($urandom_range(0, 1));
         v.ex_idx   = 5'($urandom_range(0, 7));
         v.ex_load  = 1'($urandom_range(0, 1));
         v.wb_en    = 1'($urandom_range(0, 1));
         v.wb_idx   = 5'($urandom_range(0, 7));
         v.iss      = ($urandom_range(0, 3) == 0);
         v.iss_idx  = 5'($urandom_range(0, 7));
         v.done     = ($urandom_range(0, 3) == 0);
         v.done_idx = 5'($urandom_range(0, 7));
         runCycle(v, 1'b0, 4'b0000, 1'b0, 1'b0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
